// File: rtl/muldiv_seq_if.sv
// Request/response bundle for the multi-cycle RV32M multiply/divide sequencer.
// The master (pipeline side) issues ops and consumes results; the slave is muldiv_seq.
interface muldiv_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic                  flush;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_result;
  logic                  stall;

  modport master (
    output req_valid, req_op, req_a, req_b, flush, resp_ready,
    input  req_ready, resp_valid, resp_result, stall
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, resp_ready,
    output req_ready, resp_valid, resp_result, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to compute ops 0-3 in a single cycle with a '*' multiplier.
module muldiv_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;        // multiplicand
  logic [W-1:0]     b_q, b_d;        // divisor
  logic [2*W-1:0]   acc_q, acc_d;    // product, or quotient/dividend in the low half
  logic [W-1:0]     rem_q, rem_d;    // partial remainder (always < divisor)
  logic [CNT_W-1:0] count_q, count_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             resp_valid_q, resp_valid_d;
  logic [W-1:0]     resp_result_q, resp_result_d;
  logic             stall_q, stall_d;

  // Operand conditioning for the incoming request
  logic         a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0] a_abs, b_abs;

  // One iteration of each datapath
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift, div_diff;
  logic [W-1:0]   div_rem_next, div_quo_next;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*W-1:0] fast_a, fast_b;
  logic        [2*W-1:0] fast_prod;
`endif

  assign bus.req_ready   = (state_q == IDLE) && !bus.flush;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.stall       = stall_q;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    acc_d         = acc_q;
    rem_d         = rem_q;
    count_d       = count_q;
    neg_res_d     = neg_res_q;
    neg_rem_d     = neg_rem_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;

    // MULHSU treats only rs1 as signed; the U variants treat neither.
    a_signed = bus.req_op[2] ? !bus.req_op[0] : (bus.req_op[1:0] != 2'b11);
    b_signed = bus.req_op[2] ? !bus.req_op[0] : !bus.req_op[1];
    a_neg    = a_signed && bus.req_a[W-1];
    b_neg    = b_signed && bus.req_b[W-1];
    a_abs    = a_neg ? -bus.req_a : bus.req_a;
    b_abs    = b_neg ? -bus.req_b : bus.req_b;

`ifdef MULDIV_FAST_MUL_EN
    fast_a    = {{W{a_neg}}, bus.req_a};
    fast_b    = {{W{b_neg}}, bus.req_b};
    fast_prod = fast_a * fast_b;
`endif

    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc_q[W-1:1]};

    // Trial subtraction; the sign bit of the (W+1)-bit difference picks restore or keep.
    div_shift    = {rem_q, acc_q[W-1]};
    div_diff     = div_shift - {1'b0, b_q};
    div_rem_next = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
    div_quo_next = {acc_q[W-2:0], ~div_diff[W]};

    prod_fix = neg_res_q ? -mul_next     : mul_next;
    quo_fix  = neg_res_q ? -div_quo_next : div_quo_next;
    rem_fix  = neg_rem_q ? -div_rem_next : div_rem_next;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          op_d      = bus.req_op;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          count_d   = '0;
          rem_d     = '0;
          if (bus.req_op[2]) begin
            acc_d = {{W{1'b0}}, a_abs};
            b_d   = b_abs;
            if (bus.req_b == '0) begin
              state_d       = DONE;
              resp_valid_d  = 1'b1;
              resp_result_d = bus.req_op[1] ? bus.req_a : {W{1'b1}};
            end else if (a_signed && bus.req_a == MIN_INT && bus.req_b == {W{1'b1}}) begin
              state_d       = DONE;
              resp_valid_d  = 1'b1;
              resp_result_d = bus.req_op[1] ? {W{1'b0}} : MIN_INT;
            end else begin
              state_d = CALC;
            end
          end else begin
            a_d   = a_abs;
            acc_d = {{W{1'b0}}, b_abs};
`ifdef MULDIV_FAST_MUL_EN
            state_d       = DONE;
            resp_valid_d  = 1'b1;
            resp_result_d = (bus.req_op[1:0] == 2'b00) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
`else
            state_d = CALC;
`endif
          end
        end
      end

      CALC: begin
        if (op_q[2]) begin
          acc_d = {acc_q[2*W-1:W], div_quo_next};
          rem_d = div_rem_next;
        end else begin
          acc_d = mul_next;
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(W-1)) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          if (op_q[2]) begin
            resp_result_d = op_q[1] ? rem_fix : quo_fix;
          end else begin
            resp_result_d = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
          end
        end
      end

      DONE: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase

    // Flush overrides everything, including a completing response handshake.
    if (bus.flush) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
    end

    stall_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      rem_q         <= '0;
      count_q       <= '0;
      neg_res_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      stall_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      acc_q         <= acc_d;
      rem_q         <= rem_d;
      count_q       <= count_d;
      neg_res_q     <= neg_res_d;
      neg_rem_q     <= neg_rem_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      stall_q       <= stall_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: results, latency, backpressure, flush and reset.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  muldiv_seq_if #(.DATA_WIDTH(32)) bus_if ();

  muldiv_seq #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Issue one op, measure latency to resp_valid, optionally hold off the consumer, then handshake.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.req_a     = a;
    bus_if.req_b     = b;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    bus_if.req_a     = 32'hDEAD_BEEF;
    bus_if.req_b     = 32'h0BAD_F00D;
    lat = 1;
    while (!bus_if.resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, bus_if.resp_result, exp);
    check({tag, ".stall"}, 32'(bus_if.stall), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(bus_if.resp_valid), 32'd1);
      check({tag, ".hold_result"}, bus_if.resp_result, exp);
      check({tag, ".hold_stall"}, 32'(bus_if.stall), 32'd1);
    end
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    bus_if.resp_ready = 1'b0;
    #1;
    check({tag, ".post_valid"}, 32'(bus_if.resp_valid), 32'd0);
    check({tag, ".post_stall"}, 32'(bus_if.stall), 32'd0);
  endtask

  // Start an op and leave it running; returns in the cycle after acceptance.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.req_a     = a;
    bus_if.req_b     = b;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
  endtask

  task automatic expect_no_resp(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_if.resp_valid) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks          = 0;
    n_pass            = 0;
    rst_n             = 1'b0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_op     = 3'd0;
    bus_if.req_a      = '0;
    bus_if.req_b      = '0;
    bus_if.flush      = 1'b0;
    bus_if.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.req_ready", 32'(bus_if.req_ready), 32'd1);
    check("reset.resp_valid", 32'(bus_if.resp_valid), 32'd0);
    check("reset.resp_result", bus_if.resp_result, 32'd0);
    check("reset.stall", 32'(bus_if.stall), 32'd0);
    rst_n = 1'b1;

    run_op("mul",      3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0);
    run_op("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0);
    run_op("mulh",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 0);
    run_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT, 0);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
    run_op("mulhu_2",  3'd3, 32'h8000_0000, 32'd2,         32'h0000_0001, MUL_LAT, 0);
    run_op("div",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT, 0);
    run_op("rem",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT, 0);
    run_op("divu",     3'd5, 32'd100,       32'd7,         32'd14,        DIV_LAT, 0);
    run_op("remu",     3'd7, 32'd100,       32'd7,         32'd2,         DIV_LAT, 0);
    run_op("div_negb", 3'd4, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, DIV_LAT, 0);
    run_op("rem_negb", 3'd6, 32'd20,        32'hFFFF_FFFD, 32'd2,         DIV_LAT, 0);
    run_op("divu_z",   3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,       0);
    run_op("rem_z",    3'd6, 32'd5,         32'd0,         32'd5,         1,       0);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,       0);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,       0);
    run_op("backpres", 3'd5, 32'd100,       32'd7,         32'd14,        DIV_LAT, 5);

    // Flush mid-divide: accepted at T, flush sampled at the end of T+10.
    start_op(3'd4, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus_if.flush = 1'b1;
    @(negedge clk);
    bus_if.flush = 1'b0;
    #1;
    check("flush.req_ready", 32'(bus_if.req_ready), 32'd1);
    check("flush.stall", 32'(bus_if.stall), 32'd0);
    expect_no_resp("flush.no_resp", 40);

    // Flush together with a request in IDLE blocks acceptance.
    @(negedge clk);
    bus_if.flush     = 1'b1;
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = 3'd5;
    bus_if.req_a     = 32'd9;
    bus_if.req_b     = 32'd3;
    #1;
    check("flush_idle.req_ready", 32'(bus_if.req_ready), 32'd0);
    @(negedge clk);
    bus_if.flush     = 1'b0;
    bus_if.req_valid = 1'b0;
    #1;
    check("flush_idle.stall", 32'(bus_if.stall), 32'd0);
    expect_no_resp("flush_idle.no_resp", 40);

    // Flush in DONE wins over a simultaneous handshake.
    start_op(3'd7, 32'd100, 32'd7);
    repeat (40) begin
      if (!bus_if.resp_valid) @(negedge clk);
    end
    check("flush_done.valid", 32'(bus_if.resp_valid), 32'd1);
    bus_if.flush      = 1'b1;
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    bus_if.flush      = 1'b0;
    bus_if.resp_ready = 1'b0;
    #1;
    check("flush_done.resp_valid", 32'(bus_if.resp_valid), 32'd0);
    check("flush_done.stall", 32'(bus_if.stall), 32'd0);

    // Reset mid-op at T+5 discards the divide.
    start_op(3'd4, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.req_ready", 32'(bus_if.req_ready), 32'd1);
    check("midrst.resp_valid", 32'(bus_if.resp_valid), 32'd0);
    check("midrst.resp_result", bus_if.resp_result, 32'd0);
    check("midrst.stall", 32'(bus_if.stall), 32'd0);
    rst_n = 1'b1;
    expect_no_resp("midrst.no_resp", 40);

    run_op("after_rst", 3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
